// File: rtl/writeback_unit.sv
// Purpose: final pipeline stage; writes ALU results and extracted load data to the register file and counts retirements.
// Latency: ALU result is written 1 cycle after transfer; load data is written 1 cycle after mem_rvalid.
// Backpressure: ex_ready drops while a load waits for memory; the stage then waits for mem_rvalid with no timeout.
module writeback_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [4:0]       ex_rd_addr,
    input  logic [31:0]      ex_result,
    input  logic             ex_is_load,
    input  logic [2:0]       ex_funct3,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic [4:0]       rd_addr,
    output logic [31:0]      w_data,
    output logic             w_en,
    output logic             load_fault,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q,      state_d;
    logic [4:0]       rd_addr_q,    rd_addr_d;
    logic [31:0]      w_data_q,     w_data_d;
    logic             w_en_q,       w_en_d;
    logic             load_fault_q, load_fault_d;
    logic [CNT_W-1:0] retired_q,    retired_d;
    logic [4:0]       ld_rd_q,      ld_rd_d;
    logic [2:0]       ld_funct3_q,  ld_funct3_d;
    logic [1:0]       ld_off_q,     ld_off_d;

    logic             ld_fault;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_val;

    // Accept only from IDLE; depends on state alone so there is no path from ex_valid.
    assign ex_ready   = (state_q == IDLE);
    assign rd_addr    = rd_addr_q;
    assign w_data     = w_data_q;
    assign w_en       = w_en_q;
    assign load_fault = load_fault_q;
    assign retired    = retired_q;

    // Classify the presented load: misaligned halfword/word or undefined funct3 is a fault.
    always_comb begin
        ld_fault = 1'b0;
        case (ex_funct3)
            F3_LB, F3_LBU: ld_fault = 1'b0;
            F3_LH, F3_LHU: ld_fault = ex_result[0];
            F3_LW:         ld_fault = (ex_result[1:0] != 2'b00);
            default:       ld_fault = 1'b1;
        endcase
    end

    // Lane select and sign/zero extension using the captured address offset and load type.
    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        load_val = mem_rdata;
        case (ld_off_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = ld_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ld_funct3_q)
            F3_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_val = {24'h000000, byte_sel};
            F3_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_val = {16'h0000, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    // Next-state and writeback control; w_en and load_fault are single-cycle pulses by default-low.
    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        w_data_d     = w_data_q;
        w_en_d       = 1'b0;
        load_fault_d = 1'b0;
        retired_d    = retired_q;
        ld_rd_d      = ld_rd_q;
        ld_funct3_d  = ld_funct3_q;
        ld_off_d     = ld_off_q;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (!ex_is_load) begin
                        rd_addr_d = ex_rd_addr;
                        w_data_d  = ex_result;
                        w_en_d    = (ex_rd_addr != 5'd0);
                        retired_d = retired_q + CNT_ONE;
                    end else if (ld_fault) begin
                        load_fault_d = 1'b1;
                    end else begin
                        ld_rd_d     = ex_rd_addr;
                        ld_funct3_d = ex_funct3;
                        ld_off_d    = ex_result[1:0];
                        state_d     = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    rd_addr_d = ld_rd_q;
                    w_data_d  = load_val;
                    w_en_d    = (ld_rd_q != 5'd0);
                    retired_d = retired_q + CNT_ONE;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any pending load.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rd_addr_q    <= 5'd0;
            w_data_q     <= 32'd0;
            w_en_q       <= 1'b0;
            load_fault_q <= 1'b0;
            retired_q    <= '0;
            ld_rd_q      <= 5'd0;
            ld_funct3_q  <= 3'd0;
            ld_off_q     <= 2'd0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            w_data_q     <= w_data_d;
            w_en_q       <= w_en_d;
            load_fault_q <= load_fault_d;
            retired_q    <= retired_d;
            ld_rd_q      <= ld_rd_d;
            ld_funct3_q  <= ld_funct3_d;
            ld_off_q     <= ld_off_d;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Purpose: directed self-checking bench for writeback_unit.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: load waits are driven explicitly by holding mem_rvalid low.
module tb_writeback_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ex_result;
    logic        ex_is_load;
    logic [2:0]  ex_funct3;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] w_data;
    logic        w_en;
    logic        load_fault;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    writeback_unit #(.CNT_W(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_rd_addr (ex_rd_addr),
        .ex_result  (ex_result),
        .ex_is_load (ex_is_load),
        .ex_funct3  (ex_funct3),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rd_addr    (rd_addr),
        .w_data     (w_data),
        .w_en       (w_en),
        .load_fault (load_fault),
        .retired    (retired)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid   = 1'b0;
        ex_is_load = 1'b0;
        ex_rd_addr = 5'd0;
        ex_result  = 32'd0;
        ex_funct3  = 3'd0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] res);
        ex_valid   = 1'b1;
        ex_is_load = 1'b0;
        ex_rd_addr = rd;
        ex_result  = res;
        ex_funct3  = 3'd0;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [31:0] addr, input logic [2:0] f3);
        ex_valid   = 1'b1;
        ex_is_load = 1'b1;
        ex_rd_addr = rd;
        ex_result  = addr;
        ex_funct3  = f3;
    endtask

    // One complete load: transfer, a few wait cycles with ex_ready low, then the data beat.
    task automatic run_load(input string tag, input logic [4:0] rd, input logic [31:0] addr,
                            input logic [2:0] f3, input logic [31:0] rdata, input int waits,
                            input logic [31:0] exp_data, input logic [31:0] exp_ret);
        drive_load(rd, addr, f3);
        tick();
        idle_inputs();
        check({tag, "_ready_wait"}, {31'd0, ex_ready}, 32'd0);
        check({tag, "_wen_wait"}, {31'd0, w_en}, 32'd0);
        for (int i = 1; i < waits; i++) tick();
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        idle_inputs();
        check({tag, "_wen"}, {31'd0, w_en}, 32'd1);
        check({tag, "_rd"}, {27'd0, rd_addr}, {27'd0, rd});
        check({tag, "_data"}, w_data, exp_data);
        check({tag, "_retired"}, retired, exp_ret);
        check({tag, "_ready_after"}, {31'd0, ex_ready}, 32'd1);
        tick();
        check({tag, "_wen_once"}, {31'd0, w_en}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        #12;
        check("rst_wen", {31'd0, w_en}, 32'd0);
        check("rst_rd", {27'd0, rd_addr}, 32'd0);
        check("rst_data", w_data, 32'd0);
        check("rst_fault", {31'd0, load_fault}, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_ready", {31'd0, ex_ready}, 32'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        check("post_rst_ready", {31'd0, ex_ready}, 32'd1);

        // Back-to-back ALU results, one per cycle.
        drive_alu(5'd5, 32'h11);
        tick();
        check("alu0_wen", {31'd0, w_en}, 32'd1);
        check("alu0_rd", {27'd0, rd_addr}, 32'd5);
        check("alu0_data", w_data, 32'h11);
        drive_alu(5'd6, 32'h22);
        tick();
        check("alu1_wen", {31'd0, w_en}, 32'd1);
        check("alu1_rd", {27'd0, rd_addr}, 32'd6);
        check("alu1_data", w_data, 32'h22);
        drive_alu(5'd0, 32'h33);
        tick();
        check("alu2_wen", {31'd0, w_en}, 32'd0);
        check("alu2_retired", retired, 32'd3);
        idle_inputs();
        tick();
        check("alu_idle_wen", {31'd0, w_en}, 32'd0);
        check("alu_idle_hold_retired", retired, 32'd3);

        // Signed byte from the top lane, four-cycle memory wait.
        run_load("lb", 5'd7, 32'h0000_1003, 3'b000, 32'h80FF_FF7F, 4, 32'hFFFF_FF80, 32'd4);
        // Upper halfword, zero- then sign-extended.
        run_load("lhu", 5'd8, 32'h0000_2002, 3'b101, 32'hBEEF_1234, 2, 32'h0000_BEEF, 32'd5);
        run_load("lh", 5'd9, 32'h0000_2002, 3'b001, 32'hBEEF_1234, 1, 32'hFFFF_BEEF, 32'd6);
        // Unsigned byte from lane 1 and an aligned word.
        run_load("lbu", 5'd10, 32'h0000_0005, 3'b100, 32'h1122_C344, 1, 32'h0000_00C3, 32'd7);
        run_load("lw", 5'd11, 32'h0000_3000, 3'b010, 32'h1234_5678, 3, 32'h1234_5678, 32'd8);

        // Misaligned word load faults without waiting or retiring.
        drive_load(5'd12, 32'h0000_3001, 3'b010);
        tick();
        idle_inputs();
        check("lw_mis_fault", {31'd0, load_fault}, 32'd1);
        check("lw_mis_wen", {31'd0, w_en}, 32'd0);
        check("lw_mis_ready", {31'd0, ex_ready}, 32'd1);
        check("lw_mis_retired", retired, 32'd8);
        check("lw_mis_hold_rd", {27'd0, rd_addr}, 32'd11);
        tick();
        check("lw_mis_fault_pulse", {31'd0, load_fault}, 32'd0);

        // Odd halfword and undefined funct3 fault the same way.
        drive_load(5'd13, 32'h0000_0001, 3'b101);
        tick();
        idle_inputs();
        check("lhu_mis_fault", {31'd0, load_fault}, 32'd1);
        drive_load(5'd13, 32'h0000_0000, 3'b011);
        tick();
        idle_inputs();
        check("f3_011_fault", {31'd0, load_fault}, 32'd1);
        check("f3_011_ready", {31'd0, ex_ready}, 32'd1);
        check("f3_011_retired", retired, 32'd8);

        // Stray read data in IDLE must be ignored.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        check("stray_rvalid_wen", {31'd0, w_en}, 32'd0);
        check("stray_rvalid_retired", retired, 32'd8);
        check("stray_rvalid_data", w_data, 32'h1234_5678);

        // Reset while a load is pending abandons it.
        drive_load(5'd14, 32'h0000_4000, 3'b010);
        tick();
        idle_inputs();
        check("pend_ready", {31'd0, ex_ready}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_ready", {31'd0, ex_ready}, 32'd1);
        check("async_rst_retired", retired, 32'd0);
        check("async_rst_data", w_data, 32'd0);
        tick();
        reset_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        tick();
        idle_inputs();
        check("abandon_wen", {31'd0, w_en}, 32'd0);
        check("abandon_retired", retired, 32'd0);
        check("abandon_ready", {31'd0, ex_ready}, 32'd1);

        // Counter wrap from all-ones.
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        check("preload_retired", retired, 32'hFFFF_FFFF);
        drive_alu(5'd3, 32'h44);
        tick();
        idle_inputs();
        check("wrap_wen", {31'd0, w_en}, 32'd1);
        check("wrap_retired", retired, 32'd0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
